// File: rtl/stb_gen_ctrl_pkg.sv
// stb_gen_ctrl_pkg: sequencer state and run-status encodings for stb_gen_ctrl
package stb_gen_ctrl_pkg;
    typedef enum logic [2:0] {
        IDLE,
        RESET_GEN,
        WAIT_RDY,
        CHECK,
        RUN,
        DONE
    } ctrl_state_t;

    typedef enum logic [2:0] {
        ST_OK      = 3'd0,
        ST_TIMEOUT = 3'd1,
        ST_RANGE   = 3'd2,
        ST_ABORT   = 3'd3,
        ST_GEN_ERR = 3'd4
    } ctrl_status_t;
endpackage

// File: rtl/stb_gen_ctrl.sv
// stb_gen_ctrl: sequencer for one strobe-generator channel (reset, lock wait, range check, strobe run)
//  clk_i/arst_ni                 clock, async active-low reset
//  start_i/abort_i               run control (start ignored while busy_o)
//  n_strobes_i/timeout_i         strobe count and lock timeout, latched at start
//  period_min_i/period_max_i     inclusive period bounds, latched at start
//  gen_rst_o/gen_oe_o            generator reset and strobe output enable
//  gen_rdy_i/gen_err_i           generator lock and error flags
//  gen_stb_i/gen_period_i        generator strobe and measured period
//  busy_o/done_o/status_o        run in progress, completion pulse, last-run result
//  period_o/stb_cnt_o            period captured in CHECK, strobes counted
module stb_gen_ctrl
    import stb_gen_ctrl_pkg::*;
#(
    parameter int T_CNT_WIDTH = 32,
    parameter int TO_WIDTH    = 24,
    parameter int CNT_WIDTH   = 16,
    parameter int RST_CYCLES  = 4
) (
    input  logic                   clk_i,
    input  logic                   arst_ni,
    input  logic                   start_i,
    input  logic                   abort_i,
    input  logic [CNT_WIDTH-1:0]   n_strobes_i,
    input  logic [TO_WIDTH-1:0]    timeout_i,
    input  logic [T_CNT_WIDTH-1:0] period_min_i,
    input  logic [T_CNT_WIDTH-1:0] period_max_i,
    output logic                   gen_rst_o,
    output logic                   gen_oe_o,
    input  logic                   gen_rdy_i,
    input  logic                   gen_err_i,
    input  logic                   gen_stb_i,
    input  logic [T_CNT_WIDTH-1:0] gen_period_i,
    output logic                   busy_o,
    output logic                   done_o,
    output logic [2:0]             status_o,
    output logic [T_CNT_WIDTH-1:0] period_o,
    output logic [CNT_WIDTH-1:0]   stb_cnt_o
);
    localparam int RW = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;

    ctrl_state_t            state_q, state_d;
    ctrl_status_t           status_q, status_d;
    logic [RW-1:0]          rst_cnt_q, rst_cnt_d;
    logic [TO_WIDTH-1:0]    to_cnt_q, to_cnt_d, to_q;
    logic [CNT_WIDTH-1:0]   stb_cnt_q, stb_cnt_d, n_q;
    logic [T_CNT_WIDTH-1:0] period_q, period_d, pmin_q, pmax_q;
    logic                   stb_prev_q, edge_q, cfg_ld;

    assign cfg_ld    = (state_q == IDLE) && start_i;
    assign gen_rst_o = (state_q == IDLE) || (state_q == RESET_GEN) || (state_q == DONE);
    assign gen_oe_o  = state_q == RUN;
    assign busy_o    = state_q != IDLE;
    assign done_o    = state_q == DONE;
    assign status_o  = status_q;
    assign period_o  = period_q;
    assign stb_cnt_o = stb_cnt_q;

    always_comb begin
        state_d   = state_q;
        status_d  = status_q;
        rst_cnt_d = rst_cnt_q;
        to_cnt_d  = to_cnt_q;
        stb_cnt_d = stb_cnt_q;
        period_d  = period_q;
        unique case (state_q)
            IDLE: if (start_i) begin
                state_d   = RESET_GEN;
                rst_cnt_d = '0;
                to_cnt_d  = '0;
                stb_cnt_d = '0;
            end
            RESET_GEN: begin
                rst_cnt_d = rst_cnt_q + 1'b1;
                if (rst_cnt_q == RW'(RST_CYCLES - 1)) state_d = WAIT_RDY;
            end
            WAIT_RDY: begin
                to_cnt_d = to_cnt_q + 1'b1;
                if (gen_rdy_i) begin
                    state_d = CHECK;
                end else if (to_q != '0 && to_cnt_q == to_q - 1'b1) begin
                    state_d  = DONE;
                    status_d = ST_TIMEOUT;
                end
            end
            CHECK: begin
                period_d = gen_period_i;
                if (gen_period_i >= pmin_q && gen_period_i <= pmax_q) begin
                    state_d  = (n_q == '0) ? DONE : RUN;
                    status_d = ST_OK;
                end else begin
                    state_d  = DONE;
                    status_d = ST_RANGE;
                end
            end
            RUN: if (edge_q && stb_cnt_q != n_q) begin
                stb_cnt_d = stb_cnt_q + 1'b1;
                if (stb_cnt_q + 1'b1 == n_q) begin
                    state_d  = DONE;
                    status_d = ST_OK;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        // Abort and generator error pre-empt whatever the state itself decided,
        // including a strobe increment landing in the same cycle.
        if (abort_i && state_q != IDLE && state_q != DONE) begin
            state_d   = DONE;
            status_d  = ST_ABORT;
            stb_cnt_d = stb_cnt_q;
        end else if (gen_err_i && (state_q == WAIT_RDY || state_q == RUN)) begin
            state_d   = DONE;
            status_d  = ST_GEN_ERR;
            stb_cnt_d = stb_cnt_q;
        end
    end

    always_ff @(posedge clk_i or negedge arst_ni) begin
        if (!arst_ni) begin
            state_q    <= IDLE;
            status_q   <= ST_OK;
            rst_cnt_q  <= '0;
            to_cnt_q   <= '0;
            stb_cnt_q  <= '0;
            period_q   <= '0;
            stb_prev_q <= 1'b0;
            edge_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            status_q   <= status_d;
            rst_cnt_q  <= rst_cnt_d;
            to_cnt_q   <= to_cnt_d;
            stb_cnt_q  <= stb_cnt_d;
            period_q   <= period_d;
            stb_prev_q <= gen_stb_i;
            // Registered edge pulse: the count lands one cycle after the strobe edge.
            edge_q     <= gen_stb_i & ~stb_prev_q;
        end
    end

    always_ff @(posedge clk_i or negedge arst_ni) begin
        if (!arst_ni) begin
            n_q    <= '0;
            to_q   <= '0;
            pmin_q <= '0;
            pmax_q <= '0;
        end else if (cfg_ld) begin
            n_q    <= n_strobes_i;
            to_q   <= timeout_i;
            pmin_q <= period_min_i;
            pmax_q <= period_max_i;
        end
    end
endmodule

// File: tb/tb_stb_gen_ctrl.sv
// tb_stb_gen_ctrl: directed scenarios plus random stimulus against a behavioural sequencer model
module tb_stb_gen_ctrl;
    localparam int RST = 4;

    logic        clk_i = 1'b0;
    logic        arst_ni = 1'b0;
    logic        start_i = 1'b0, abort_i = 1'b0;
    logic [15:0] n_strobes_i = '0;
    logic [23:0] timeout_i = '0;
    logic [31:0] period_min_i = '0, period_max_i = '0;
    logic        gen_rst_o, gen_oe_o;
    logic        gen_rdy_i = 1'b0, gen_err_i = 1'b0, gen_stb_i = 1'b0;
    logic [31:0] gen_period_i = '0;
    logic        busy_o, done_o;
    logic [2:0]  status_o;
    logic [31:0] period_o;
    logic [15:0] stb_cnt_o;

    stb_gen_ctrl #(.T_CNT_WIDTH(32), .TO_WIDTH(24), .CNT_WIDTH(16), .RST_CYCLES(RST)) dut (
        .clk_i(clk_i), .arst_ni(arst_ni), .start_i(start_i), .abort_i(abort_i),
        .n_strobes_i(n_strobes_i), .timeout_i(timeout_i),
        .period_min_i(period_min_i), .period_max_i(period_max_i),
        .gen_rst_o(gen_rst_o), .gen_oe_o(gen_oe_o), .gen_rdy_i(gen_rdy_i),
        .gen_err_i(gen_err_i), .gen_stb_i(gen_stb_i), .gen_period_i(gen_period_i),
        .busy_o(busy_o), .done_o(done_o), .status_o(status_o),
        .period_o(period_o), .stb_cnt_o(stb_cnt_o)
    );

    always #5 clk_i = ~clk_i;

    int vecs = 0, errs = 0;
    int cyc = 0;
    bit oe_seen = 0;

    // Model: phase 0 idle, 1 generator reset, 2 wait lock, 3 check, 4 run, 5 done.
    // Phase timing is measured from the cycle stamp t0 at which the phase was entered.
    int          ph = 0, t0 = 0;
    bit          e1 = 0, s1 = 0;
    logic [2:0]  m_st = 0;
    logic [31:0] m_per = 0, l_min = 0, l_max = 0;
    logic [15:0] m_cnt = 0, l_n = 0;
    logic [23:0] l_to = 0;

    task automatic model_reset();
        ph = 0; m_st = 0; m_per = 0; m_cnt = 0; e1 = 0; s1 = 0;
    endtask

    task automatic model_tick();
        bit ev;
        int nx;
        ev = e1;
        e1 = gen_stb_i & ~s1;
        s1 = gen_stb_i;
        cyc++;
        nx = ph;
        if (ph == 3) m_per = gen_period_i;
        if (ph >= 1 && ph <= 4 && abort_i) begin
            nx = 5; m_st = 3;
        end else if ((ph == 2 || ph == 4) && gen_err_i) begin
            nx = 5; m_st = 4;
        end else begin
            case (ph)
                0: if (start_i) begin
                    nx = 1; t0 = cyc; m_cnt = 0;
                    l_n = n_strobes_i; l_to = timeout_i; l_min = period_min_i; l_max = period_max_i;
                end
                1: if (cyc - t0 == RST) begin nx = 2; t0 = cyc; end
                2: if (gen_rdy_i) nx = 3;
                   else if (l_to != 0 && cyc - t0 == int'(l_to)) begin nx = 5; m_st = 1; end
                3: if (gen_period_i >= l_min && gen_period_i <= l_max) begin
                       nx = (l_n == 0) ? 5 : 4; m_st = 0;
                   end else begin
                       nx = 5; m_st = 2;
                   end
                4: if (ev) begin
                       m_cnt++;
                       if (m_cnt == l_n) begin nx = 5; m_st = 0; end
                   end
                default: nx = 0;
            endcase
        end
        ph = nx;
    endtask

    task automatic compare();
        logic e_rst, e_oe, e_busy, e_done;
        e_rst  = (ph == 0 || ph == 1 || ph == 5);
        e_oe   = (ph == 4);
        e_busy = (ph != 0);
        e_done = (ph == 5);
        vecs++;
        if ({gen_rst_o, gen_oe_o, busy_o, done_o} !== {e_rst, e_oe, e_busy, e_done} ||
            status_o !== m_st || period_o !== m_per || stb_cnt_o !== m_cnt) begin
            errs++;
            $display("FAIL cycle %0d: rst/oe/busy/done=%b%b%b%b st=%0d per=%0d cnt=%0d, want %b%b%b%b st=%0d per=%0d cnt=%0d",
                     cyc, gen_rst_o, gen_oe_o, busy_o, done_o, status_o, period_o, stb_cnt_o,
                     e_rst, e_oe, e_busy, e_done, m_st, m_per, m_cnt);
        end
    endtask

    task automatic step();
        @(posedge clk_i);
        if (!arst_ni) model_reset(); else model_tick();
        @(negedge clk_i);
        if (gen_oe_o) oe_seen = 1;
        compare();
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vecs++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic go(input int n, input int to, input int mn, input int mx);
        n_strobes_i = 16'(n); timeout_i = 24'(to); period_min_i = mn; period_max_i = mx;
        oe_seen = 0;
        start_i = 1; step(); start_i = 0;
    endtask

    task automatic wait_release();
        int k = 0;
        while (gen_rst_o && k < 20) begin step(); k++; end
        chk("release_bound", gen_rst_o, 0);
    endtask

    task automatic wait_done(input int lim, output int n);
        n = 0;
        while (!done_o && n < lim) begin step(); n++; end
        chk("done_bound", done_o, 1);
    endtask

    task automatic to_run(input int n, input int p);
        go(n, 0, 90, 110);
        wait_release();
        gen_rdy_i = 1; gen_period_i = p; step();
        gen_rdy_i = 0; step();
        chk("in_run", gen_oe_o, 1);
    endtask

    task automatic pulse();
        gen_stb_i = 1; step(); gen_stb_i = 0; step(); step();
    endtask

    initial begin
        int k, d;
        step(); step();
        chk("rst_gen_rst", gen_rst_o, 1);
        chk("rst_busy", busy_o, 0);
        chk("rst_status", status_o, 0);
        chk("rst_cnt", stb_cnt_o, 0);
        arst_ni = 1; step();

        // 1: nominal three-strobe run
        go(3, 0, 90, 110);
        k = 0;
        while (gen_rst_o && busy_o && k < 20) begin k++; step(); end
        chk("s1_rst_len", k, 4);
        repeat (9) step();
        gen_rdy_i = 1; gen_period_i = 100; step();
        gen_rdy_i = 0; step();
        pulse(); pulse();
        gen_stb_i = 1; step(); gen_stb_i = 0;
        wait_done(20, d);
        chk("s1_edge_to_done", d, 1);
        chk("s1_status", status_o, 0);
        chk("s1_period", period_o, 100);
        chk("s1_cnt", stb_cnt_o, 3);
        step();
        chk("s1_done_once", done_o, 0);

        // 2: lock timeout
        go(3, 50, 0, 1000);
        wait_release();
        wait_done(100, d);
        chk("s2_timeout_len", d, 50);
        chk("s2_status", status_o, 1);
        chk("s2_no_oe", oe_seen, 0);
        step();

        // 3: out of range, then inverted bounds
        go(2, 0, 90, 110);
        wait_release();
        gen_rdy_i = 1; gen_period_i = 120; step(); gen_rdy_i = 0;
        wait_done(10, d);
        chk("s3a_status", status_o, 2);
        chk("s3a_period", period_o, 120);
        step();
        go(2, 0, 200, 100);
        wait_release();
        gen_rdy_i = 1; gen_period_i = 150; step(); gen_rdy_i = 0;
        wait_done(10, d);
        chk("s3b_status", status_o, 2);
        chk("s3_no_oe", oe_seen, 0);
        step();

        // 4: abort after two of five strobes
        to_run(5, 100);
        pulse(); pulse(); step();
        chk("s4_cnt_pre", stb_cnt_o, 2);
        abort_i = 1; step(); abort_i = 0;
        chk("s4_done", done_o, 1);
        chk("s4_status", status_o, 3);
        chk("s4_cnt", stb_cnt_o, 2);
        chk("s4_oe", gen_oe_o, 0);
        step();

        // 5: abort beats gen_err; gen_err in WAIT_RDY; async reset mid-run
        to_run(4, 100);
        abort_i = 1; gen_err_i = 1; step(); abort_i = 0; gen_err_i = 0;
        chk("s5a_status", status_o, 3);
        step();
        go(4, 0, 90, 110);
        wait_release();
        gen_err_i = 1; step(); gen_err_i = 0;
        chk("s5b_done", done_o, 1);
        chk("s5b_status", status_o, 4);
        step();
        to_run(4, 105);
        pulse();
        chk("s5c_cnt_pre", stb_cnt_o, 1);
        #2 arst_ni = 0;
        #1;
        chk("s5c_rst", gen_rst_o, 1);
        chk("s5c_oe", gen_oe_o, 0);
        chk("s5c_busy", busy_o, 0);
        chk("s5c_status", status_o, 0);
        chk("s5c_period", period_o, 0);
        chk("s5c_cnt", stb_cnt_o, 0);
        model_reset();
        step();
        arst_ni = 1; step();

        // 6: zero strobes, then start held high for back-to-back runs
        go(0, 0, 90, 110);
        wait_release();
        gen_rdy_i = 1; gen_period_i = 95; step(); gen_rdy_i = 0;
        wait_done(10, d);
        chk("s6a_status", status_o, 0);
        chk("s6a_no_oe", oe_seen, 0);
        step();
        n_strobes_i = 0; gen_rdy_i = 1; start_i = 1;
        wait_done(30, d);
        step();
        chk("s6b_idle_gap", busy_o, 0);
        wait_done(30, d);
        chk("s6b_period", d + 1, 8);
        start_i = 0; gen_rdy_i = 0;
        step(); step();

        // Random traffic
        for (int i = 0; i < 4000; i++) begin
            start_i      = ($urandom_range(7) == 0);
            abort_i      = ($urandom_range(63) == 0);
            gen_err_i    = ($urandom_range(63) == 0);
            gen_rdy_i    = ($urandom_range(5) == 0);
            if ($urandom_range(2) == 0) gen_stb_i = ~gen_stb_i;
            n_strobes_i  = 16'($urandom_range(3));
            timeout_i    = 24'($urandom_range(12));
            period_min_i = $urandom_range(12);
            period_max_i = $urandom_range(12);
            gen_period_i = $urandom_range(12);
            if ($urandom_range(499) == 0) begin
                #2 arst_ni = 0;
                #1 model_reset();
                step();
                arst_ni = 1;
            end else begin
                step();
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end
endmodule
